// File: rtl/jpeg_dht_pkg.sv
// Shared types and constants for the JPEG DHT table store.
package jpeg_dht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNTS,
        ST_SYMS,
        ST_DONE
    } dht_state_e;

    localparam int unsigned YDC = 0;
    localparam int unsigned YAC = 1;
    localparam int unsigned CDC = 2;
    localparam int unsigned CAC = 3;

    localparam int unsigned NUM_LENGTHS = 16;
    localparam int unsigned TOTAL_W     = 12;

endpackage

// File: rtl/jpeg_dht_ram.sv
// Simple dual-port RAM: synchronous write, registered read, read-before-write.
module jpeg_dht_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the read register is reset; the array keeps its contents.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/jpeg_dht_store.sv
// DHT segment parser and Huffman symbol/count store with 1-cycle read port.
// Optional per-bank valid flags and read gating: JPEG_DHT_TABLE_VALID_EN.
module jpeg_dht_store
    import jpeg_dht_pkg::*;
#(
    parameter int unsigned NUM_TABLES = 4,
    parameter int unsigned SYM_DEPTH  = 256,
    parameter int unsigned ADDR_W     = $clog2(SYM_DEPTH),
    localparam int unsigned TBL_W     = $clog2(NUM_TABLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic                  InStart,
    input  logic [7:0]            InData,
    output logic                  LoadDone,
    output logic                  LoadError,
    input  logic [TBL_W-1:0]      ReadTable,
    input  logic [ADDR_W-1:0]     ReadAddr,
    output logic [3:0]            ZeroTable,
    output logic [3:0]            WidthTable,
    input  logic [3:0]            CountLen,
`ifdef JPEG_DHT_TABLE_VALID_EN
    output logic [NUM_TABLES-1:0] TableValid,
`endif
    output logic [7:0]            CountData
);

    localparam int unsigned LEN_W = $clog2(NUM_LENGTHS);

    dht_state_e         r_state, w_state_nxt;
    logic               r_in_ready, r_load_done, r_load_err;
    logic [TBL_W-1:0]   r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [TOTAL_W-1:0] r_total, r_sym_cnt;

    logic               w_acc, w_hdr, w_hdr_ok, w_err, w_start;
    logic               w_cnt_we, w_sym_we;
    logic [4:0]         w_hdr_idx;
    logic [TOTAL_W-1:0] w_total_sum;
    logic [7:0]         w_sym_q, w_cnt_q;

    assign w_acc       = InValid && r_in_ready;
    assign w_hdr       = w_acc && InStart;
    // Index is Th*2 + Tc; only meaningful when Tc is 0 or 1.
    assign w_hdr_idx   = {InData[3:0], InData[4]};
    assign w_hdr_ok    = (InData[7:4] <= 4'd1) && (32'(w_hdr_idx) < NUM_TABLES);
    assign w_total_sum = r_total + TOTAL_W'(InData);
    assign w_cnt_we    = w_acc && !InStart && (r_state == ST_COUNTS);
    assign w_sym_we    = w_acc && !InStart && (r_state == ST_SYMS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A header byte restarts parsing from any accepting state.
    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        w_start     = 1'b0;
        if (w_hdr) begin
            if (w_hdr_ok) begin
                w_start     = 1'b1;
                w_state_nxt = ST_COUNTS;
            end else begin
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            if (r_state != ST_IDLE) begin
                w_err = 1'b1;
            end
        end else begin
            case (r_state)
                ST_COUNTS: begin
                    if (w_cnt_we && (r_len == LEN_W'(NUM_LENGTHS - 1))) begin
                        if (w_total_sum > TOTAL_W'(SYM_DEPTH)) begin
                            w_err       = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else if (w_total_sum == '0) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt = ST_SYMS;
                        end
                    end
                end
                ST_SYMS: begin
                    if (w_sym_we && ((r_sym_cnt + TOTAL_W'(1)) == r_total)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE:  w_state_nxt = ST_IDLE;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in_ready  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_idx       <= '0;
            r_len       <= '0;
            r_total     <= '0;
            r_sym_cnt   <= '0;
        end else begin
            r_in_ready  <= (w_state_nxt != ST_DONE);
            r_load_done <= (w_state_nxt == ST_DONE);
            r_load_err  <= w_err;
            if (w_start) begin
                r_idx   <= TBL_W'(w_hdr_idx);
                r_len   <= '0;
                r_total <= '0;
            end else if (w_cnt_we) begin
                r_len   <= r_len + LEN_W'(1);
                r_total <= w_total_sum;
            end
            if (w_start || w_cnt_we) begin
                r_sym_cnt <= '0;
            end else if (w_sym_we) begin
                r_sym_cnt <= r_sym_cnt + TOTAL_W'(1);
            end
        end
    end

    jpeg_dht_ram #(
        .DEPTH (NUM_TABLES * SYM_DEPTH),
        .WIDTH (8)
    ) u_sym_ram (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_sym_we),
        .i_waddr ({r_idx, ADDR_W'(r_sym_cnt)}),
        .i_wdata (InData),
        .i_raddr ({ReadTable, ReadAddr}),
        .o_rdata (w_sym_q)
    );

    jpeg_dht_ram #(
        .DEPTH (NUM_TABLES * NUM_LENGTHS),
        .WIDTH (8)
    ) u_cnt_ram (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_we    (w_cnt_we),
        .i_waddr ({r_idx, r_len}),
        .i_wdata (InData),
        .i_raddr ({ReadTable, CountLen}),
        .o_rdata (w_cnt_q)
    );

    assign InReady   = r_in_ready;
    assign LoadDone  = r_load_done;
    assign LoadError = r_load_err;

`ifdef JPEG_DHT_TABLE_VALID_EN
    logic [NUM_TABLES-1:0] r_valid;
    logic                  r_rd_ok;

    // Flag is sampled alongside the RAM read so gating lines up with the data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_rd_ok <= 1'b0;
        end else begin
            r_rd_ok <= r_valid[ReadTable];
            if (w_start) begin
                r_valid[TBL_W'(w_hdr_idx)] <= 1'b0;
            end else if (w_state_nxt == ST_DONE && r_state != ST_DONE) begin
                r_valid[r_idx] <= 1'b1;
            end
        end
    end

    assign TableValid = r_valid;
    assign ZeroTable  = r_rd_ok ? w_sym_q[7:4] : 4'd0;
    assign WidthTable = r_rd_ok ? w_sym_q[3:0] : 4'd0;
    assign CountData  = r_rd_ok ? w_cnt_q : 8'd0;
`else
    assign ZeroTable  = w_sym_q[7:4];
    assign WidthTable = w_sym_q[3:0];
    assign CountData  = w_cnt_q;
`endif

endmodule
